// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters onto a single cache port,
// one transaction in flight, with an optional per-transaction timeout.
module cache_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          cache_valid_o,
    input  logic                          cache_ready_i,
    output logic                          cache_we_o,
    output logic [ADDR_WIDTH-1:0]         cache_adr_o,
    output logic [DATA_WIDTH-1:0]         cache_wdata_o,
    input  logic [DATA_WIDTH-1:0]         cache_rdata_i,
    input  logic                          cache_resp_valid_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    owner_o
);

    localparam int OW = $clog2(NUM_REQ);
    // One spare count so an ISSUE handshake on the last allowed cycle still expires in WAIT.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q;
    logic [OW-1:0]         rr_q;
    logic [OW-1:0]         owner_q;
    logic [CW-1:0]         cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  cache_valid_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;

    logic [OW-1:0]         winner;
    logic                  grant_found;
    int                    scan_idx;
    logic                  expired;
    logic [CW-1:0]         cnt_inc;
    logic [OW-1:0]         rr_next;
    logic [NUM_REQ-1:0]    owner_oh;

    always_comb begin
        winner      = rr_q;
        grant_found = 1'b0;
        scan_idx    = 0;
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                winner      = OW'(scan_idx);
            end
        end
        if (state_q == S_IDLE && grant_found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign expired  = (TIMEOUT != 0) && (cnt_q >= CNT_LIMIT);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    assign rr_next  = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
    assign owner_oh = NUM_REQ'(1) << owner_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            rsp_valid_q   <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_q       <= winner;
                        we_q          <= req_we_i[winner];
                        adr_q         <= req_adr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q       <= req_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        cnt_q         <= '0;
                        cache_valid_q <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_inc;
                    if (cache_ready_i) begin
                        cache_valid_q <= 1'b0;
                        state_q       <= S_WAIT;
                    end else if (expired) begin
                        cache_valid_q <= 1'b0;
                        rdata_q       <= '0;
                        err_q         <= 1'b1;
                        rsp_valid_q   <= owner_oh;
                        state_q       <= S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_inc;
                    // A response arriving on the expiry cycle takes priority over the timeout.
                    if (cache_resp_valid_i) begin
                        rdata_q     <= cache_rdata_i;
                        err_q       <= 1'b0;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end else if (expired) begin
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rr_q    <= rr_next;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign cache_valid_o = cache_valid_q;
    assign cache_we_o    = we_q;
    assign cache_adr_o   = adr_q;
    assign cache_wdata_o = wdata_q;
    assign busy_o        = (state_q != S_IDLE);
    assign owner_o       = owner_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: two requesters, TIMEOUT shortened to 8
// so expiry and expiry/response coincidence can be hit with a few cycles.
module tb_cache_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [NR-1:0]  req_valid_i;
    logic [NR-1:0]  req_ready_o;
    logic [NR-1:0]  req_we_i;
    logic [NR*AW-1:0] req_adr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR-1:0]  rsp_valid_o;
    logic [DW-1:0]  rsp_rdata_o;
    logic           rsp_err_o;
    logic           cache_valid_o;
    logic           cache_ready_i;
    logic           cache_we_o;
    logic [AW-1:0]  cache_adr_o;
    logic [DW-1:0]  cache_wdata_o;
    logic [DW-1:0]  cache_rdata_i;
    logic           cache_resp_valid_i;
    logic           busy_o;
    logic [$clog2(NR)-1:0] owner_o;

    int vecCount  = 0;
    int missCount = 0;

    cache_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .cache_valid_o(cache_valid_o), .cache_ready_i(cache_ready_i), .cache_we_o(cache_we_o),
        .cache_adr_o(cache_adr_o), .cache_wdata_o(cache_wdata_o),
        .cache_rdata_i(cache_rdata_i), .cache_resp_valid_i(cache_resp_valid_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tickClock();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid, input logic cacheReady,
                                 input logic respValid, input logic [DW-1:0] rdata);
        req_valid_i        = valid;
        cache_ready_i      = cacheReady;
        cache_resp_valid_i = respValid;
        cache_rdata_i      = rdata;
    endtask

    task automatic applyReset();
        rst_i = 1'b1;
        tickClock();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_we_i    = '0;
        req_adr_i   = '0;
        req_wdata_i = '0;
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        tickClock();
        tickClock();
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_cache_valid", cache_valid_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp_err", rsp_err_o, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata_o, 0);
        checkOutput("rst_owner", owner_o, 0);
        rst_i = 1'b0;
        tickClock();

        // Single read, minimum latency
        req_adr_i = {16'h5678, 16'h1234};
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        #1;
        checkOutput("rd_ready", req_ready_o, 2'b01);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        checkOutput("rd_issue_valid", cache_valid_o, 1);
        checkOutput("rd_issue_adr", cache_adr_o, 16'h1234);
        checkOutput("rd_issue_we", cache_we_o, 0);
        checkOutput("rd_busy", busy_o, 1);
        checkOutput("rd_ready_busy", req_ready_o, 2'b00);
        tickClock();
        checkOutput("rd_wait_valid", cache_valid_o, 0);
        checkOutput("rd_wait_rsp", rsp_valid_o, 2'b00);
        applyStimulus(2'b00, 1'b1, 1'b1, 32'hDEADBEEF);
        tickClock();
        checkOutput("rd_rsp_valid", rsp_valid_o, 2'b01);
        checkOutput("rd_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);
        checkOutput("rd_rsp_err", rsp_err_o, 0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        tickClock();
        checkOutput("rd_rsp_pulse", rsp_valid_o, 2'b00);
        checkOutput("rd_idle_busy", busy_o, 0);
        checkOutput("rd_rdata_hold", rsp_rdata_o, 32'hDEADBEEF);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        #1;
        checkOutput("rd_rr_advanced", req_ready_o, 2'b10);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);

        // Fairness with both requesters held valid, back-to-back
        applyReset();
        req_we_i = 2'b10;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(2'b11, 1'b1, 1'b1, 32'h1000_0000 + t);
            #1;
            checkOutput("fair_ready", req_ready_o, (t % 2 == 0) ? 2'b01 : 2'b10);
            tickClock();
            checkOutput("fair_owner", owner_o, t % 2);
            checkOutput("fair_adr", cache_adr_o, (t % 2 == 0) ? 16'h1234 : 16'h5678);
            checkOutput("fair_we", cache_we_o, t % 2);
            tickClock();
            tickClock();
            checkOutput("fair_rsp", rsp_valid_o, (t % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("fair_rdata", rsp_rdata_o, 32'h1000_0000 + t);
            tickClock();
        end

        // Backpressure on the cache request channel
        req_adr_i   = {16'hBEEF, 16'h1234};
        req_wdata_i = {32'hCAFEF00D, 32'h0};
        applyStimulus(2'b10, 1'b0, 1'b0, '0);
        #1;
        checkOutput("bp_ready", req_ready_o, 2'b10);
        tickClock();
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", cache_valid_o, 1);
            checkOutput("bp_adr", cache_adr_o, 16'hBEEF);
            tickClock();
        end
        checkOutput("bp_wdata", cache_wdata_o, 32'hCAFEF00D);
        checkOutput("bp_we", cache_we_o, 1);
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h11223344);
        tickClock();
        checkOutput("bp_rsp", rsp_valid_o, 2'b10);
        checkOutput("bp_rdata", rsp_rdata_o, 32'h11223344);
        checkOutput("bp_err", rsp_err_o, 0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        tickClock();

        // Timeout while waiting for the cache response
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) tickClock();
        checkOutput("to_not_early", rsp_valid_o, 2'b00);
        tickClock();
        checkOutput("to_rsp", rsp_valid_o, 2'b01);
        checkOutput("to_err", rsp_err_o, 1);
        checkOutput("to_rdata", rsp_rdata_o, 0);
        applyStimulus(2'b10, 1'b1, 1'b0, '0);
        tickClock();
        checkOutput("to_pulse", rsp_valid_o, 2'b00);
        checkOutput("to_next_ready", req_ready_o, 2'b10);
        tickClock();
        checkOutput("to_next_busy", busy_o, 1);
        checkOutput("to_next_owner", owner_o, 1);
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h55AA55AA);
        tickClock();
        checkOutput("to_next_err", rsp_err_o, 0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        tickClock();

        // Timeout while the cache never accepts the request
        applyStimulus(2'b01, 1'b0, 1'b0, '0);
        tickClock();
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) tickClock();
        checkOutput("toi_last_valid", cache_valid_o, 1);
        tickClock();
        checkOutput("toi_dropped", cache_valid_o, 0);
        checkOutput("toi_rsp", rsp_valid_o, 2'b01);
        checkOutput("toi_err", rsp_err_o, 1);
        tickClock();

        // Response arriving on the expiry cycle; req0 wins via wrap from rr=1
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        #1;
        checkOutput("co_ready_wrap", req_ready_o, 2'b01);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) tickClock();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'hA5A5A5A5);
        tickClock();
        checkOutput("co_rsp", rsp_valid_o, 2'b01);
        checkOutput("co_err", rsp_err_o, 0);
        checkOutput("co_rdata", rsp_rdata_o, 32'hA5A5A5A5);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        tickClock();

        // Reset in WAIT, then a stray cache response
        applyStimulus(2'b10, 1'b1, 1'b0, '0);
        tickClock();
        applyStimulus(2'b00, 1'b1, 1'b0, '0);
        tickClock();
        checkOutput("rw_busy_before", busy_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("rw_async_busy", busy_o, 0);
        checkOutput("rw_async_owner", owner_o, 0);
        #1;
        rst_i = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h77777777);
        tickClock();
        checkOutput("rw_stray_rsp", rsp_valid_o, 2'b00);
        tickClock();
        checkOutput("rw_stray_rsp2", rsp_valid_o, 2'b00);
        checkOutput("rw_busy", busy_o, 0);
        checkOutput("rw_rdata", rsp_rdata_o, 0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        #1;
        checkOutput("rw_rr_zero", req_ready_o, 2'b01);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
